// File: rtl/am_err_pkg.sv
// Shared types and widths for the approximate-multiplier error monitor.
// Holds the run FSM states, the default counter width and the |err| helper.
package am_err_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  localparam int CNT_W_D  = 17;
  localparam int SAE_W_D  = 16 + CNT_W_D;
  localparam int SSE_W_D  = 32 + CNT_W_D;
  localparam int BIAS_W_D = 17 + CNT_W_D;

  // |e| of a 17-bit signed error always fits 16 bits (range -65025..65535)
  function automatic logic [15:0] abs17(input logic signed [16:0] e);
    logic [16:0] m;
    if (e[16]) m = 17'(-e);
    else m = 17'(e);
    return m[15:0];
  endfunction

endpackage

// File: rtl/am_exact_mul8.sv
// Registered exact 8x8 unsigned multiplier (first pipeline stage).
// Also serves as the golden product model in other harness blocks.
module am_exact_mul8 (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  input  logic [7:0]  x,
  input  logic [7:0]  y,
  output logic        out_valid,
  output logic [15:0] exact
);

  // valid bit; a flush discards whatever is in flight
  always_ff @(posedge clk) begin
    if (rst || flush) out_valid <= 1'b0;
    else out_valid <= in_valid;
  end

  // product register, loaded only on an accepted sample
  always_ff @(posedge clk) begin
    if (rst) exact <= '0;
    else if (in_valid) exact <= 16'(x) * 16'(y);
  end

endmodule

// File: rtl/am_error_monitor_8x8.sv
// Streaming error-statistics accumulator for 8x8 approximate multipliers.
// FSM + accept counter, S1 exact product, S2 square stage, accumulators.
module am_error_monitor_8x8
  import am_err_pkg::*;
#(
  parameter  int CNT_W  = CNT_W_D,
  localparam int SAE_W  = 16 + CNT_W,
  localparam int SSE_W  = 32 + CNT_W,
  localparam int BIAS_W = 17 + CNT_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  input  logic [CNT_W-1:0]         n_samples,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [7:0]               x,
  input  logic [7:0]               y,
  input  logic [15:0]              z,
  output logic                     done,
  output logic [CNT_W-1:0]         sample_cnt,
  output logic [CNT_W-1:0]         err_cnt,
  output logic [SAE_W-1:0]         sum_abs_err,
  output logic [SSE_W-1:0]         sum_sq_err,
  output logic signed [BIAS_W-1:0] sum_err,
  output logic [15:0]              max_abs_err
);

  state_t state, state_nx;

  logic [CNT_W-1:0] n_reg;
  logic [CNT_W-1:0] acc_cnt;
  logic             beat;
  logic             go;

  logic               s1_valid;
  logic [15:0]        s1_exact;
  logic [15:0]        s1_z;
  logic signed [16:0] s1_err;
  logic [15:0]        s1_abs;
  logic [31:0]        s1_sq;

  logic               s2_valid;
  logic signed [16:0] s2_err;
  logic [15:0]        s2_abs;
  logic [31:0]        s2_sq;

  assign in_ready = (state == RUN);
  assign done     = (state == DONE);
  assign beat     = in_valid & in_ready;

  // next state; abort overrides everything, including a start
  always_comb begin
    state_nx = state;
    go       = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          go       = 1'b1;
          state_nx = (n_samples == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (beat && acc_cnt == n_reg - CNT_W'(1))
          state_nx = DRAIN;
      end
      DRAIN: begin
        if (!s1_valid) state_nx = DONE;
      end
      default: state_nx = IDLE;
    endcase
    if (abort) begin
      state_nx = IDLE;
      go       = 1'b0;
    end
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_nx;
  end

  // run length latch and accepted-beat counter
  always_ff @(posedge clk) begin
    if (rst) begin
      n_reg   <= '0;
      acc_cnt <= '0;
    end else if (go) begin
      n_reg   <= n_samples;
      acc_cnt <= '0;
    end else if (beat) begin
      acc_cnt <= acc_cnt + CNT_W'(1);
    end
  end

  am_exact_mul8 u_mul (
    .clk       (clk),
    .rst       (rst),
    .flush     (abort),
    .in_valid  (beat),
    .x         (x),
    .y         (y),
    .out_valid (s1_valid),
    .exact     (s1_exact)
  );

  // approximate product travels alongside the exact one
  always_ff @(posedge clk) begin
    if (rst) s1_z <= '0;
    else if (beat) s1_z <= z;
  end

  // signed error, magnitude and square from the S1 registers
  always_comb begin
    s1_err = signed'({1'b0, s1_z}) - signed'({1'b0, s1_exact});
    s1_abs = abs17(s1_err);
    s1_sq  = 32'(s1_abs) * 32'(s1_abs);
  end

  // S2 valid; abort drops in-flight beats
  always_ff @(posedge clk) begin
    if (rst || abort) s2_valid <= 1'b0;
    else s2_valid <= s1_valid;
  end

  // S2 data registers
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_err <= '0;
      s2_abs <= '0;
      s2_sq  <= '0;
    end else if (s1_valid) begin
      s2_err <= s1_err;
      s2_abs <= s1_abs;
      s2_sq  <= s1_sq;
    end
  end

  // accumulators: cleared on accepted start, updated per S2 beat
  always_ff @(posedge clk) begin
    if (rst || go) begin
      sample_cnt  <= '0;
      err_cnt     <= '0;
      sum_abs_err <= '0;
      sum_sq_err  <= '0;
      sum_err     <= '0;
      max_abs_err <= '0;
    end else if (s2_valid) begin
      sample_cnt  <= sample_cnt + CNT_W'(1);
      err_cnt     <= err_cnt + CNT_W'(s2_err != '0);
      sum_abs_err <= sum_abs_err + SAE_W'(s2_abs);
      sum_sq_err  <= sum_sq_err + SSE_W'(s2_sq);
      sum_err     <= sum_err + BIAS_W'(s2_err);
      if (s2_abs > max_abs_err) max_abs_err <= s2_abs;
    end
  end

endmodule

// File: tb/tb_am_error_monitor_8x8.sv
// Scoreboard bench for am_error_monitor_8x8.
// Per-run expectations are queued while driving and popped at done.
module tb_am_error_monitor_8x8;

  localparam int CW = 17;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              abort;
  logic [CW-1:0]     n_samples;
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        x;
  logic [7:0]        y;
  logic [15:0]       z;
  logic              done;
  logic [CW-1:0]     sample_cnt;
  logic [CW-1:0]     err_cnt;
  logic [CW+15:0]    sum_abs_err;
  logic [CW+31:0]    sum_sq_err;
  logic signed [CW+16:0] sum_err;
  logic [15:0]       max_abs_err;

  always #5 clk = ~clk;

  am_error_monitor_8x8 #(.CNT_W(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .n_samples   (n_samples),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .x           (x),
    .y           (y),
    .z           (z),
    .done        (done),
    .sample_cnt  (sample_cnt),
    .err_cnt     (err_cnt),
    .sum_abs_err (sum_abs_err),
    .sum_sq_err  (sum_sq_err),
    .sum_err     (sum_err),
    .max_abs_err (max_abs_err)
  );

  typedef struct {
    longint cnt;
    longint ecnt;
    longint sae;
    longint sse;
    longint se;
    longint mx;
  } exp_t;

  exp_t sb[$];
  exp_t m;
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input longint got,
                     input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic mclr();
    m = '{default: 0};
  endtask

  task automatic model(input logic [7:0] a, input logic [7:0] b,
                       input logic [15:0] c);
    longint e, ae;
    e  = longint'(c) - longint'(a) * longint'(b);
    ae = (e < 0) ? -e : e;
    m.cnt++;
    if (e != 0) m.ecnt++;
    m.sae += ae;
    m.sse += ae * ae;
    m.se  += e;
    if (ae > m.mx) m.mx = ae;
  endtask

  task automatic go_run(input logic [CW-1:0] n);
    start     = 1'b1;
    n_samples = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b,
                      input logic [15:0] c, input bit gap);
    int t;
    t = 0;
    while (in_ready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (in_ready !== 1'b1) chk("ready_wait", 0, 1);
    if (gap) begin
      in_valid = 1'b0;
      x = 8'($urandom);
      y = 8'($urandom);
      z = 16'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b1;
    x = a;
    y = b;
    z = c;
    model(a, b, c);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_chk(input string tag);
    int   t;
    exp_t e;
    t = 0;
    while (done !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_done"}, longint'(done), 1);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 0, 1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_cnt"}, longint'(sample_cnt), e.cnt);
      chk({tag, "_ecnt"}, longint'(err_cnt), e.ecnt);
      chk({tag, "_sae"}, longint'(sum_abs_err), e.sae);
      chk({tag, "_sse"}, longint'(sum_sq_err), e.sse);
      chk({tag, "_se"}, longint'(sum_err), e.se);
      chk({tag, "_max"}, longint'(max_abs_err), e.mx);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    n_samples = '0;
    in_valid  = 1'b0;
    x = '0;
    y = '0;
    z = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", longint'(in_ready), 0);
    chk("rst_done", longint'(done), 0);
    chk("rst_cnt", longint'(sample_cnt), 0);
    chk("rst_sse", longint'(sum_sq_err), 0);
    rst = 1'b0;
    @(negedge clk);

    // reset in the middle of a run
    mclr();
    go_run(10);
    for (int i = 0; i < 5; i++) send(8'(i + 1), 8'd7, 16'd0, 1'b0);
    chk("t1_pre_cnt", longint'(sample_cnt), 3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t1_ready", longint'(in_ready), 0);
    chk("t1_done", longint'(done), 0);
    chk("t1_cnt", longint'(sample_cnt), 0);
    chk("t1_sae", longint'(sum_abs_err), 0);
    chk("t1_se", longint'(sum_err), 0);
    chk("t1_max", longint'(max_abs_err), 0);
    @(negedge clk);
    chk("t1_idle", longint'(in_ready), 0);

    // three-beat run, one off-by-one error
    mclr();
    go_run(3);
    send(8'd3, 8'd5, 16'd15, 1'b0);
    send(8'd255, 8'd255, 16'd65025, 1'b0);
    send(8'd0, 8'd9, 16'd1, 1'b0);
    sb.push_back('{cnt: 3, ecnt: 1, sae: 1, sse: 1, se: 1, mx: 1});
    wait_chk("t2");
    repeat (3) @(negedge clk);
    chk("t2_hold_done", longint'(done), 1);
    chk("t2_hold_sse", longint'(sum_sq_err), 1);

    // negative bias run, restarted from DONE
    mclr();
    go_run(2);
    send(8'd16, 8'd16, 16'd200, 1'b0);
    send(8'd2, 8'd3, 16'd10, 1'b0);
    chk("t3_ready_low", longint'(in_ready), 0);
    sb.push_back('{cnt: 2, ecnt: 2, sae: 60, sse: 3152, se: -52, mx: 56});
    wait_chk("t3");

    // zero-length run
    go_run(0);
    chk("t4_done", longint'(done), 1);
    chk("t4_ready", longint'(in_ready), 0);
    chk("t4_cnt", longint'(sample_cnt), 0);
    chk("t4_sae", longint'(sum_abs_err), 0);
    chk("t4_sse", longint'(sum_sq_err), 0);
    chk("t4_max", longint'(max_abs_err), 0);
    @(negedge clk);
    chk("t4_ready2", longint'(in_ready), 0);

    // random short run against the model
    mclr();
    go_run(24);
    for (int i = 0; i < 24; i++) begin
      logic [7:0]  a, b;
      logic [15:0] c;
      a = 8'($urandom);
      b = 8'($urandom);
      c = ($urandom_range(0, 1) == 0) ? 16'(a) * 16'(b) : 16'($urandom);
      send(a, b, c, $urandom_range(0, 2) == 0);
    end
    sb.push_back(m);
    wait_chk("rnd");

    // exact products, gapped
    mclr();
    go_run(4096);
    for (int i = 0; i < 4096; i++) begin
      logic [7:0] a, b;
      a = i[7:0];
      b = 8'(i[11:8] * 17);
      send(a, b, 16'(a) * 16'(b), $urandom_range(0, 3) == 0);
    end
    sb.push_back(m);
    wait_chk("t5_exact");

    // exhaustive sweep with z = 0
    mclr();
    go_run(17'd65536);
    for (int i = 0; i < 65536; i++)
      send(i[7:0], i[15:8], 16'd0, $urandom_range(0, 31) == 0);
    sb.push_back(m);
    wait_chk("t5_zero");
    chk("t5_sample_cnt", longint'(sample_cnt), 65536);
    chk("t5_sae_abs", longint'(sum_abs_err), 64'd1065369600);
    chk("t5_max_abs", longint'(max_abs_err), 65025);

    // abort one cycle after a beat
    go_run(4);
    send(8'd1, 8'd2, 16'd9, 1'b0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t6_ready", longint'(in_ready), 0);
    chk("t6_done", longint'(done), 0);
    repeat (3) @(negedge clk);
    chk("t6_cnt", longint'(sample_cnt), 0);
    chk("t6_sae", longint'(sum_abs_err), 0);

    // start together with abort while DONE
    go_run(0);
    chk("t6_done_pre", longint'(done), 1);
    start     = 1'b1;
    abort     = 1'b1;
    n_samples = 5;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("t6_sa_done", longint'(done), 0);
    chk("t6_sa_ready", longint'(in_ready), 0);
    @(negedge clk);
    chk("t6_sa_ready2", longint'(in_ready), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
